net_mux_valve_seq: RTL
======================

# net_mux_valve_seq

Pneumatic control sequencer that drives the six air lines (c1..c6) of the 8-channel cell-trap multiplexer. One run moves through four steps: load the traps, wash through k1 or k2, elute into the mixer tree, and close all valves. Between steps every valve is closed for a set time (break-before-make). The block sits directly upstream of the multiplexer and connects to its control ports one-to-one.

## Interface
- LOAD_T, 16: cycles c1 is held open (inputs i1..i8 into traps).
- WASH_T, 16: cycles the wash path (c2 plus c3 or c4) is held open.
- ELUTE_T, 16: cycles the elution path (c5, c6) is held open.
- SETTLE_T, 4: cycles with all valves closed between steps. All parameters are ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled in IDLE only.
- abort  in  1  abandon the current run; sampled while busy.
- wash_sel  in  1  0 = wash via k1 (c3), 1 = wash via k2 (c4); latched when start is accepted.
- c1..c6  out  1 each  valve air lines; 1 = valve open.
- busy  out  1  high while a run or abort is in progress.
- done  out  1  one-cycle pulse when a run completes normally.
- aborted  out  1  one-cycle pulse when abort handling completes.
- phase  out  3  state code: IDLE=0, LOAD=1, WASH=2, ELUTE=3, SETTLE=4, DONE=5, ABORT=6.

## Operation
- States: IDLE, LOAD, WASH, ELUTE, SETTLE, DONE, ABORT. A register `ret` records the step that follows SETTLE (WASH, ELUTE or DONE).
- IDLE: all outputs 0. When start=1: latch wash_sel, load the timer with LOAD_T-1, go to LOAD.
- LOAD: c1=1, all other valves 0. On timer expiry, go to SETTLE with ret=WASH.
- WASH: c2=1, c3=~wsel, c4=wsel. On expiry, go to SETTLE with ret=ELUTE.
- ELUTE: c5=1, c6=1. On expiry, go to SETTLE with ret=DONE.
- SETTLE: c1..c6 all 0 for SETTLE_T cycles, then go to ret and reload the timer with that step's duration minus 1.
- DONE: busy=0, done=1 for one cycle, then IDLE.
- abort=1 in LOAD, WASH, ELUTE or SETTLE:
  - Go to ABORT and load the timer with SETTLE_T-1.
  - ABORT closes all valves. On expiry, aborted=1 for one cycle and the block returns to IDLE.
  - abort has priority over timer expiry in the same cycle.
- Ignored inputs:
  - abort in IDLE, DONE or ABORT (ABORT is not restarted).
  - start while busy, or in DONE.
- Invariants, asserted in the bench:
  - c1 never overlaps c2..c6.
  - c3 and c4 are never both high.
  - Between any two different non-zero valve patterns there are at least SETTLE_T all-zero cycles.
- Timer: down-counter, width $clog2(max(LOAD_T, WASH_T, ELUTE_T, SETTLE_T)). Expiry means count==0. No wrap-around: the timer is always reloaded on a state change.

## Timing
- Reset value of every output is 0: c1..c6, busy, done, aborted, and phase (IDLE).
- Reset asserted mid-run closes all valves immediately (asynchronously). No pulse is generated.
- All outputs are registered; there is no combinational path from any input to any output.
- Cycle numbering: start is sampled at edge E0. LOAD is visible from E1 and the step lasts exactly LOAD_T cycles. Each later step lasts exactly its parameter in cycles.
- busy is high for LOAD_T+WASH_T+ELUTE_T+3·SETTLE_T cycles.
- done is high in the cycle immediately after busy falls.
- abort sampled at edge Ea: valves are 0 from Ea+1, aborted pulses in cycle Ea+SETTLE_T+1, and busy is 0 from that same cycle.
- Back-to-back runs: start is first accepted at the edge after the done cycle.

## Test plan
Configuration for all scenarios: LOAD_T=4, WASH_T=3, ELUTE_T=5, SETTLE_T=2.

- Reset: hold rst with start=1, then release and keep start=0 → all outputs stay 0 and phase=0.
- Normal run, wash_sel=0: start at E0.
  - c1=1 for E1–E4; all valves 0 for E5–E6.
  - c2=c3=1 for E7–E9; 0 for E10–E11.
  - c5=c6=1 for E12–E16; 0 for E17–E18.
  - busy high for 18 cycles; done=1 at E19.
- wash_sel=1 latched at start, then toggled mid-run → c4 is used for the whole WASH step and c3 stays 0.
- abort at E8 (during WASH) → valves 0 from E9, aborted=1 at E11, busy=0 at E11, done never asserts.
- Simultaneous events:
  - abort on the last LOAD cycle (E4) → ABORT is entered, not SETTLE.
  - start pulsed during a run → ignored.
  - abort in IDLE → ignored.
- Reset asserted at E13 (ELUTE) → c5 and c6 drop to 0 immediately; after release the block is in IDLE and a new start produces the full normal sequence.

Source files
------------

// File: rtl/net_mux_valve_seq.sv
// Break-before-make valve sequencer for the 8-channel cell-trap multiplexer:
// load -> settle -> wash -> settle -> elute -> settle -> done, with abort handling.
module net_mux_valve_seq #(
  parameter int LOAD_T   = 16,
  parameter int WASH_T   = 16,
  parameter int ELUTE_T  = 16,
  parameter int SETTLE_T = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       wash_sel,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       c5,
  output logic       c6,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [2:0] phase
);

  localparam int MAX_LW = (LOAD_T > WASH_T) ? LOAD_T : WASH_T;
  localparam int MAX_ES = (ELUTE_T > SETTLE_T) ? ELUTE_T : SETTLE_T;
  localparam int MAX_T  = (MAX_LW > MAX_ES) ? MAX_LW : MAX_ES;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0] LOAD_LD   = TW'(LOAD_T - 1);
  localparam logic [TW-1:0] WASH_LD   = TW'(WASH_T - 1);
  localparam logic [TW-1:0] ELUTE_LD  = TW'(ELUTE_T - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_T - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WASH   = 3'd2,
    ELUTE  = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5,
    ABORT  = 3'd6
  } state_t;

  state_t        state;
  state_t        ret;
  logic [TW-1:0] timer;
  logic          wsel;
  logic          abort_pend;

  wire expired = (timer == '0);
  wire running = (state == LOAD) || (state == WASH) || (state == ELUTE) || (state == SETTLE);

  // Outputs are decoded from the state held during the previous cycle, so every
  // output is one register stage behind the sequencer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ret        <= WASH;
      timer      <= '0;
      wsel       <= 1'b0;
      abort_pend <= 1'b0;
      c1         <= 1'b0;
      c2         <= 1'b0;
      c3         <= 1'b0;
      c4         <= 1'b0;
      c5         <= 1'b0;
      c6         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      phase      <= 3'd0;
    end else begin
      c1         <= (state == LOAD);
      c2         <= (state == WASH);
      c3         <= (state == WASH) && !wsel;
      c4         <= (state == WASH) && wsel;
      c5         <= (state == ELUTE);
      c6         <= (state == ELUTE);
      busy       <= running || (state == ABORT);
      done       <= (state == DONE);
      aborted    <= abort_pend;
      phase      <= state;
      abort_pend <= 1'b0;

      if (running && abort) begin
        // abort wins over a coincident timer expiry
        state <= ABORT;
        timer <= SETTLE_LD;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              wsel  <= wash_sel;
              state <= LOAD;
              timer <= LOAD_LD;
            end
          end
          LOAD: begin
            if (expired) begin
              state <= SETTLE;
              ret   <= WASH;
              timer <= SETTLE_LD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          WASH: begin
            if (expired) begin
              state <= SETTLE;
              ret   <= ELUTE;
              timer <= SETTLE_LD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          ELUTE: begin
            if (expired) begin
              state <= SETTLE;
              ret   <= DONE;
              timer <= SETTLE_LD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          SETTLE: begin
            if (expired) begin
              state <= ret;
              case (ret)
                WASH:    timer <= WASH_LD;
                ELUTE:   timer <= ELUTE_LD;
                default: timer <= '0;
              endcase
            end else begin
              timer <= timer - 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          ABORT: begin
            if (expired) begin
              state      <= IDLE;
              abort_pend <= 1'b1;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule
